// File: rtl/conv1d_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module      : conv1d_ctrl                                                |
// | Description : 1-D convolution controller. Loads N unsigned 8-bit samples |
// |               and M unsigned 8-bit taps over two valid/ready streams,    |
// |               then produces the N+M-1 full-convolution outputs one at a  |
// |               time (low 8 bits of each sum) on a valid/ready output,     |
// |               using a single 8x8 multiply-accumulate per cycle.          |
// | Ports       : clk, rst (async, active-high)                              |
// |               start               - begin a job (only seen when idle)    |
// |               a/a_valid/a_ready   - sample stream                        |
// |               b/b_valid/b_ready   - tap stream                           |
// |               out/out_valid/out_ready - result stream                    |
// |               busy                - job in progress                      |
// |               done                - one-cycle end-of-job pulse           |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module conv1d_ctrl #(
    parameter int N = 5,
    parameter int M = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] a,
    input  logic       a_valid,
    output logic       a_ready,
    input  logic [7:0] b,
    input  logic       b_valid,
    output logic       b_ready,
    output logic [7:0] out,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy,
    output logic       done
);

    localparam int CA_W  = $clog2(N + 1);          // sample count 0..N
    localparam int CB_W  = $clog2(M + 1);          // tap count / tap index 0..M
    localparam int IX_W  = $clog2(N + M + 1);      // output index arithmetic
    localparam int AI_W  = (N > 1) ? $clog2(N) : 1;
    localparam int BI_W  = (M > 1) ? $clog2(M) : 1;
    localparam int ACC_W = 16 + $clog2(M);

    localparam logic [2:0] c_st_idle = 3'd0;
    localparam logic [2:0] c_st_load = 3'd1;
    localparam logic [2:0] c_st_mac  = 3'd2;
    localparam logic [2:0] c_st_hold = 3'd3;
    localparam logic [2:0] c_st_fin  = 3'd4;

    localparam logic [CA_W-1:0] c_n_ca   = CA_W'(N);
    localparam logic [CB_W-1:0] c_m_cb   = CB_W'(M);
    localparam logic [CB_W-1:0] c_one_cb = CB_W'(1);
    localparam logic [IX_W-1:0] c_n_ix   = IX_W'(N);
    localparam logic [IX_W-1:0] c_m_ix   = IX_W'(M);
    localparam logic [IX_W-1:0] c_one_ix = IX_W'(1);
    localparam logic [IX_W-1:0] c_klast  = IX_W'(N + M - 2);

    logic [2:0]       r_state;
    logic [CA_W-1:0]  r_na;
    logic [CB_W-1:0]  r_nb;
    logic [IX_W-1:0]  r_k;
    logic [CB_W-1:0]  r_j;       // next tap index to fetch
    logic             r_pv;      // r_prod holds a product not yet accumulated
    logic [15:0]      r_prod;
    logic [ACC_W-1:0] r_acc;
    logic [7:0]       r_amem [N];
    logic [7:0]       r_bmem [M];

    logic             w_fire_a;
    logic             w_fire_b;
    logic [CA_W-1:0]  w_na_nx;
    logic [CB_W-1:0]  w_nb_nx;
    logic             w_load_done;
    logic [IX_W-1:0]  w_fk;
    logic [CB_W-1:0]  w_fj;
    logic [IX_W-1:0]  w_fj_x;
    logic             w_in_rng;
    logic [AI_W-1:0]  w_ai;
    logic [BI_W-1:0]  w_bi;
    logic [15:0]      w_term;
    logic [ACC_W-1:0] w_sum;

    assign w_fire_a    = a_valid & a_ready;
    assign w_fire_b    = b_valid & b_ready;
    assign w_na_nx     = r_na + CA_W'(w_fire_a);
    assign w_nb_nx     = r_nb + CB_W'(w_fire_b);
    // Final beats may land on the same edge that completes the load.
    assign w_load_done = (w_na_nx == c_n_ca) && (w_nb_nx == c_m_cb);

    // Product fetch runs one cycle ahead of the accumulator. While holding a
    // result, the first product (j=0) of the next output is prefetched so the
    // consume edge can launch it; a fresh job has nothing prefetched, which
    // costs one pipeline-fill cycle before y[0].
    assign w_fk     = (r_state == c_st_hold) ? (r_k + c_one_ix) : r_k;
    assign w_fj     = (r_state == c_st_hold) ? '0 : r_j;
    assign w_fj_x   = IX_W'(w_fj);
    assign w_in_rng = (w_fj_x < c_m_ix) && (w_fk >= w_fj_x) &&
                      ((w_fk - w_fj_x) < c_n_ix);
    assign w_ai     = AI_W'(w_fk - w_fj_x);
    assign w_bi     = BI_W'(w_fj);

    always_comb begin
        w_term = '0;
        if (w_in_rng) begin
            w_term = 16'(r_amem[w_ai]) * 16'(r_bmem[w_bi]);
        end
    end

    assign w_sum = r_acc + ACC_W'(r_prod);

    // Operand storage is not reset; it survives idle periods.
    always_ff @(posedge clk) begin
        if (w_fire_a) r_amem[AI_W'(r_na)] <= a;
        if (w_fire_b) r_bmem[BI_W'(r_nb)] <= b;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= c_st_idle;
            r_na      <= '0;
            r_nb      <= '0;
            r_k       <= '0;
            r_j       <= '0;
            r_pv      <= 1'b0;
            r_prod    <= '0;
            r_acc     <= '0;
            a_ready   <= 1'b0;
            b_ready   <= 1'b0;
            out       <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        r_state <= c_st_load;
                        r_na    <= '0;
                        r_nb    <= '0;
                        r_k     <= '0;
                        r_j     <= '0;
                        r_pv    <= 1'b0;
                        a_ready <= 1'b1;
                        b_ready <= 1'b1;
                        busy    <= 1'b1;
                    end
                end
                c_st_load: begin
                    r_na <= w_na_nx;
                    r_nb <= w_nb_nx;
                    if (w_load_done) begin
                        r_state <= c_st_mac;
                        a_ready <= 1'b0;
                        b_ready <= 1'b0;
                        r_k     <= '0;
                        r_j     <= '0;
                        r_pv    <= 1'b0;
                        r_acc   <= '0;
                    end else begin
                        a_ready <= (w_na_nx != c_n_ca);
                        b_ready <= (w_nb_nx != c_m_cb);
                    end
                end
                c_st_mac: begin
                    if (r_pv && (r_j == c_m_cb)) begin
                        // Last product of this output: publish the sum.
                        r_acc     <= w_sum;
                        out       <= w_sum[7:0];
                        out_valid <= 1'b1;
                        r_pv      <= 1'b0;
                        r_state   <= c_st_hold;
                    end else begin
                        if (r_pv) r_acc <= w_sum;
                        r_prod <= w_term;
                        r_pv   <= 1'b1;
                        r_j    <= r_j + c_one_cb;
                    end
                end
                c_st_hold: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (r_k == c_klast) begin
                            r_state <= c_st_fin;
                            done    <= 1'b1;
                        end else begin
                            r_state <= c_st_mac;
                            r_k     <= r_k + c_one_ix;
                            r_prod  <= w_term;
                            r_pv    <= 1'b1;
                            r_j     <= c_one_cb;
                            r_acc   <= '0;
                        end
                    end
                end
                c_st_fin: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= c_st_idle;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_conv1d_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module      : tb_conv1d_ctrl                                             |
// | Description : Self-checking bench for conv1d_ctrl: table vectors, hand   |
// |               sequences (latency, backpressure, start-while-busy, reset  |
// |               mid-job) and random jobs against a convolution model.      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_conv1d_ctrl;

    localparam int N = 5;
    localparam int M = 3;
    localparam int K = N + M - 1;

    typedef logic [N-1:0][7:0] avec_t;
    typedef logic [M-1:0][7:0] bvec_t;
    typedef logic [K-1:0][7:0] yvec_t;
    typedef struct packed {
        avec_t a;
        bvec_t b;
        yvec_t y;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] a = '0;
    logic       a_valid = 1'b0;
    logic       a_ready;
    logic [7:0] b = '0;
    logic       b_valid = 1'b0;
    logic       b_ready;
    logic [7:0] out;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic       busy;
    logic       done;

    int checks = 0;
    int failures = 0;
    int done_total = 0;

    conv1d_ctrl #(.N(N), .M(M)) dut (
        .clk(clk), .rst(rst), .start(start),
        .a(a), .a_valid(a_valid), .a_ready(a_ready),
        .b(b), .b_valid(b_valid), .b_ready(b_ready),
        .out(out), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done) done_total++;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full linear convolution, low 8 bits of every sum.
    function automatic yvec_t model(input avec_t av, input bvec_t bv);
        yvec_t y;
        for (int k = 0; k < K; k++) begin
            int s = 0;
            for (int j = 0; j < M; j++) begin
                if (k - j >= 0 && k - j < N) s += int'(av[k-j]) * int'(bv[j]);
            end
            y[k] = 8'(s);
        end
        return y;
    endfunction

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_after_start", busy, 1);
    endtask

    // mode 0: random gaps plus junk beats once a stream is full.
    // mode 1: no gaps, b delayed so the last a and last b share one edge.
    task automatic load(input avec_t av, input bvec_t bv, input int mode);
        int ia = 0;
        int ib = 0;
        int cyc = 0;
        bit fa, fb;
        while ((ia < N || ib < M) && cyc < 200) begin
            if (mode == 1) begin
                a_valid = (ia < N);
                b_valid = (ib < M) && (cyc >= N - M);
            end else begin
                a_valid = (ia < N) ? ($urandom_range(3) != 0) : ($urandom_range(1) == 1);
                b_valid = (ib < M) ? ($urandom_range(3) != 0) : ($urandom_range(1) == 1);
            end
            a = (ia < N) ? av[ia] : 8'($urandom);
            b = (ib < M) ? bv[ib] : 8'($urandom);
            @(negedge clk);
            chk("a_ready_load", a_ready, (ia < N));
            chk("b_ready_load", b_ready, (ib < M));
            fa = a_valid && a_ready;
            fb = b_valid && b_ready;
            tick();
            if (fa) ia++;
            if (fb) ib++;
            cyc++;
        end
        if (cyc >= 200) begin
            checks++;
            failures++;
            $display("FAIL load_timeout: got ia=%0d ib=%0d expected %0d/%0d", ia, ib, N, M);
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
    endtask

    task automatic wait_valid(input int exp_lat, input string name, input bit poke_start);
        int cnt = 0;
        while (!out_valid && cnt < 50) begin
            if (poke_start && cnt == 1) start = 1'b1;
            tick();
            start = 1'b0;
            cnt++;
        end
        chk(name, cnt, exp_lat);
    endtask

    // bp_mode 0: none, 1: random 0..3 stall cycles, 2: 10 stall cycles on y[3].
    // Returns early (no consume) once y[stop_k] has been checked, if stop_k < K.
    task automatic collect(input yvec_t ye, input int bp_mode, input bit poke, input int stop_k);
        int dbefore = done_total;
        int hold;
        for (int k = 0; k < K; k++) begin
            wait_valid((k == 0) ? M + 1 : M, (k == 0) ? "latency_first" : "latency_next",
                       poke && (k == 0));
            chk("out_value", out, ye[k]);
            if (k == stop_k) return;
            hold = (bp_mode == 1) ? int'($urandom_range(3)) : ((bp_mode == 2 && k == 3) ? 10 : 0);
            for (int h = 0; h < hold; h++) begin
                tick();
                chk("hold_valid", out_valid, 1);
                chk("hold_out", out, ye[k]);
                chk("hold_ready", {a_ready, b_ready}, 0);
            end
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end
        chk("done_pulse", done, 1);
        tick();
        chk("done_after", done, 0);
        chk("busy_after", busy, 0);
        chk("done_count", done_total - dbefore, 1);
    endtask

    vec_t tbl [5];

    initial begin
        // Packed arrays: rightmost literal is element 0.
        tbl[0].a = {8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
        tbl[0].b = {8'd3, 8'd2, 8'd1};
        tbl[0].y = {8'd15, 8'd22, 8'd22, 8'd16, 8'd10, 8'd4, 8'd1};
        tbl[1].a = {8'd255, 8'd255, 8'd255, 8'd255, 8'd255};
        tbl[1].b = {8'd255, 8'd255, 8'd255};
        tbl[1].y = {8'd1, 8'd2, 8'd3, 8'd3, 8'd3, 8'd2, 8'd1};
        tbl[2].a = {8'd50, 8'd40, 8'd30, 8'd20, 8'd10};
        tbl[2].b = {8'd0, 8'd1, 8'd0};
        tbl[2].y = {8'd0, 8'd50, 8'd40, 8'd30, 8'd20, 8'd10, 8'd0};
        tbl[3].a = {8'd50, 8'd40, 8'd30, 8'd20, 8'd10};
        tbl[3].b = {8'd0, 8'd0, 8'd2};
        tbl[3].y = {8'd0, 8'd0, 8'd100, 8'd80, 8'd60, 8'd40, 8'd20};
        tbl[4].a = {8'd1, 8'd0, 8'd0, 8'd100, 8'd200};
        tbl[4].b = {8'd0, 8'd3, 8'd2};
        tbl[4].y = {8'd0, 8'd3, 8'd2, 8'd0, 8'd44, 8'd32, 8'd144};

        // Reset values, asserted asynchronously at time 0.
        #1;
        chk("rst_out", out, 0);
        chk("rst_flags", {out_valid, a_ready, b_ready, busy, done}, 0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("idle_busy", busy, 0);

        // Table vectors. Entry 0: aligned final beats, 10-cycle stall on y[3].
        // Entry 1: start pulsed during MAC.
        for (int i = 0; i < 5; i++) begin
            do_start();
            load(tbl[i].a, tbl[i].b, (i == 0) ? 1 : 0);
            collect(tbl[i].y, (i == 0) ? 2 : 1, (i == 1), K);
            tick();
        end

        // Reset while y[2] is held; everything must drop at once.
        begin
            int dbefore;
            dbefore = done_total;
            do_start();
            load(tbl[0].a, tbl[0].b, 0);
            collect(tbl[0].y, 0, 1'b0, 2);
            #2;
            rst = 1'b1;
            #1;
            chk("midrst_out", out, 0);
            chk("midrst_flags", {out_valid, a_ready, b_ready, busy, done}, 0);
            tick();
            rst = 1'b0;
            for (int c = 0; c < 4; c++) tick();
            chk("midrst_idle", {busy, out_valid, a_ready}, 0);
            chk("midrst_nodone", done_total - dbefore, 0);
            do_start();
            load(tbl[4].a, tbl[4].b, 0);
            collect(tbl[4].y, 1, 1'b0, K);
        end

        // Random jobs against the model.
        for (int r = 0; r < 8; r++) begin
            avec_t av;
            bvec_t bv;
            for (int i = 0; i < N; i++) av[i] = 8'($urandom);
            for (int j = 0; j < M; j++) bv[j] = 8'($urandom);
            tick();
            do_start();
            load(av, bv, int'($urandom_range(1)));
            collect(model(av, bv), 1, (r % 3 == 0), K);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/conv1d_ctrl.md
CONV1D_CTRL -- requirements
Module: conv1d_ctrl

Interface
REQ-001 Parameter N, default 5, number of input samples per job.
REQ-002 Parameter M, default 3, number of kernel taps per job.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  begins a job; sampled only in IDLE.
REQ-006 a  input  8  unsigned sample data.
REQ-007 a_valid  input  1  sample on a is valid.
REQ-008 a_ready  output  1  controller accepts a sample this cycle.
REQ-009 b  input  8  unsigned tap data.
REQ-010 b_valid  input  1  tap on b is valid.
REQ-011 b_ready  output  1  controller accepts a tap this cycle.
REQ-012 out  output  8  result word, low 8 bits of the full sum.
REQ-013 out_valid  output  1  out holds a valid result.
REQ-014 out_ready  input  1  downstream consumes out.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 done  output  1  one-cycle pulse after the last result is consumed.

Function
REQ-017 The FSM SHALL have states IDLE, LOAD, MAC, HOLD and FIN.
REQ-018 IDLE -> LOAD on start=1; sample, tap, output and tap-index counters cleared on that edge.
REQ-019 In LOAD, a_ready SHALL equal (samples stored < N) and b_ready SHALL equal (taps stored < M); both low in all other states.
REQ-020 A sample is stored at index = sample count on each edge with a_valid & a_ready; taps likewise with b_valid & b_ready; both streams may transfer on the same edge.
REQ-021 Valid beats with ready low SHALL be ignored and SHALL NOT alter stored data.
REQ-022 LOAD -> MAC on the edge where N samples and M taps are both stored, including when the final beats arrive on that same edge.
REQ-023 The controller SHALL produce y[k] = sum over j=0..M-1 of a[k-j]*b[j] for k = 0..N+M-2, with terms where k-j is outside 0..N-1 contributing zero.
REQ-024 MAC SHALL spend exactly M cycles per output, using one 8x8 multiply-accumulate per cycle (j = 0..M-1), with the accumulator cleared at the start of each output.
REQ-025 The accumulator width SHALL be at least 16+ceil(log2(M)) bits; out = accumulator[7:0] (modulo 256, with no saturation).
REQ-026 MAC -> HOLD after the M-th cycle; out_valid=1 and out stable throughout HOLD.
REQ-027 In HOLD with out_ready=1, the result is consumed: go to MAC for k+1 if k < N+M-2, else go to FIN.
REQ-028 In HOLD with out_ready=0, the state and out SHALL be held indefinitely.
REQ-029 FIN SHALL assert done for exactly one cycle, then return to IDLE.
REQ-030 start while busy=1 SHALL be ignored.
REQ-031 Latency: out_valid for y[0] SHALL rise M+1 edges after the edge completing LOAD; with out_ready held high, each subsequent result follows M+1 edges after the previous.
REQ-032 Stored samples and taps SHALL persist in IDLE; they are overwritten only by a new LOAD.

Reset
REQ-033 rst=1 SHALL immediately force IDLE and clear all counters and the accumulator, setting out=0, out_valid=0, a_ready=0, b_ready=0, busy=0 and done=0.
REQ-034 rst asserted mid-job (any state) SHALL abort the job with no done pulse; the next job requires a new start after rst deasserts.
REQ-035 Contents of the storage arrays are don't-care after reset.

Verification
REQ-036 Basic: start; a=1,2,3,4,5; b=1,2,3; out_ready=1 -> out sequence 1,4,10,16,22,22,15, then a single done pulse.
REQ-037 Timing: with the streams above, interleaved so that the final a beat and the final b beat land on the same edge -> out_valid for y[0] rises exactly M+1=4 edges later.
REQ-038 Wrap: all a=255, b=255 -> y[0]=0x01, y[2]=0x03, y[6]=0x01.
REQ-039 Backpressure: out_ready=0 for 10 cycles during y[3] -> out_valid stays 1 with out=16 unchanged; sequence resumes intact afterwards; a_ready and b_ready stay low.
REQ-040 Overflow beats and restart: an extra a beat after 5 samples is ignored (a_ready=0); start pulsed during MAC is ignored; a second job after done produces correct results.
REQ-041 Reset mid-job: rst during HOLD of y[2] -> all outputs zero immediately, no done pulse; a new start with fresh data gives correct results.
